// File: rtl/mips_mc_core_if.sv
// Memory port of mips_mc_core: a single request/ready channel shared by
// instruction fetch and data load/store.
interface mips_mc_core_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;
  logic              mem_ready_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-I subset core with integrated control FSM, ready-handshaked memory port,
// memory-mapped GPIO register and retire strobe. Define MIPS_MC_TRAP_EN to halt on illegal ops.
module mips_mc_core #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int unsigned GPIO_W    = 8,
  parameter logic [31:0] GPIO_ADDR = 32'h1001_0024
) (
  input  logic              clk,
  input  logic              reset,
  mips_mc_core_if.master    mem,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              retire_o,
  output logic [31:0]       pc_o,
  output logic              trap_o
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
    StAluWb, StIExec, StIWb, StBranch, StJump, StTrap
  } state_e;

  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        req, we, retire, dec_illegal, funct_ok;
  logic [31:0] bus_addr, r_result, i_result;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] sign_imm, zero_imm;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign sign_imm = {{16{imm[15]}}, imm};
  assign zero_imm = {16'h0000, imm};

  always_comb begin
    r_result = '0;
    funct_ok = 1'b1;
    case (funct)
      6'h20:   r_result = a_q + b_q;
      6'h22:   r_result = a_q - b_q;
      6'h24:   r_result = a_q & b_q;
      6'h25:   r_result = a_q | b_q;
      6'h27:   r_result = ~(a_q | b_q);
      6'h2A:   r_result = {31'b0, $signed(a_q) < $signed(b_q)};
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OpAndi:  i_result = a_q & zero_imm;
      OpOri:   i_result = a_q | zero_imm;
      OpLui:   i_result = {imm, 16'h0000};
      default: i_result = a_q + sign_imm;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_out_d   = alu_out_q;
    mdr_d       = mdr_q;
    gpio_d      = gpio_q;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    req         = 1'b0;
    we          = 1'b0;
    bus_addr    = pc_q;
    retire      = 1'b0;
    dec_illegal = 1'b0;

    unique case (state_q)
      StFetch: begin
        req = 1'b1;
        if (mem.mem_ready_i) begin
          ir_d    = mem.mem_rdata_i;
          pc_d    = pc_q + 32'd4;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d       = rf_q[rs];
        b_d       = rf_q[rt];
        alu_out_d = pc_q + {sign_imm[29:0], 2'b00};
        case (op)
          OpRtype: begin
            if (funct_ok) state_d = StExec;
            else          dec_illegal = 1'b1;
          end
          OpLw, OpSw:                   state_d = StMemAdr;
          OpAddi, OpAndi, OpOri, OpLui: state_d = StIExec;
          OpBeq, OpBne:                 state_d = StBranch;
          OpJ:                          state_d = StJump;
          default:                      dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
`ifdef MIPS_MC_TRAP_EN
          state_d = StTrap;
`else
          retire  = 1'b1;
          state_d = StFetch;
`endif
        end
      end
      StMemAdr: begin
        alu_out_d = a_q + sign_imm;
        state_d   = (op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        req      = 1'b1;
        bus_addr = alu_out_q;
        if (mem.mem_ready_i) begin
          mdr_d   = mem.mem_rdata_i;
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = mdr_q;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        // GPIO stores complete locally in one cycle and never reach memory.
        if (alu_out_q == GPIO_ADDR) begin
          gpio_d  = b_q[GPIO_W-1:0];
          retire  = 1'b1;
          state_d = StFetch;
        end else begin
          req      = 1'b1;
          we       = 1'b1;
          bus_addr = alu_out_q;
          if (mem.mem_ready_i) begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StExec: begin
        alu_out_d = r_result;
        state_d   = StAluWb;
      end
      StAluWb: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        rf_wdata = alu_out_q;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StIExec: begin
        alu_out_d = i_result;
        state_d   = StIWb;
      end
      StIWb: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = alu_out_q;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        if ((op == OpBeq) == (a_q == b_q)) pc_d = alu_out_q;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StJump: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        retire  = 1'b1;
        state_d = StFetch;
      end
      StTrap: state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      gpio_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      gpio_q    <= gpio_d;
    end
  end

  // $0 is never written, so it reads as zero without a read-side mux.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Reset masks the request combinationally so an in-flight access drops at once.
  assign mem.mem_req_o   = req & reset;
  assign mem.mem_we_o    = we & reset;
  assign mem.mem_addr_o  = bus_addr[ADDR_W-1:0];
  assign mem.mem_wdata_o = b_q;

  assign gpio_o   = gpio_q;
  assign retire_o = retire;
  assign pc_o     = pc_q;

`ifdef MIPS_MC_TRAP_EN
  assign trap_o = (state_q == StTrap);
`else
  assign trap_o = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: ISA-level reference model stepped on each retire,
// plus directed programs with hand-computed results.
module tb_mips_mc_core;
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] GPIO_ADDR = 32'h1001_0024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  gpio;
  logic        retire, trap;
  logic [31:0] pc;

  mips_mc_core_if #(.ADDR_W(32)) bus ();

  mips_mc_core #(
    .ADDR_W(32), .RESET_PC(RESET_PC), .GPIO_W(8), .GPIO_ADDR(GPIO_ADDR)
  ) dut (
    .clk(clk), .reset(reset), .mem(bus), .gpio_o(gpio), .retire_o(retire),
    .pc_o(pc), .trap_o(trap)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [64];
  logic [31:0] dinit [64];
  logic [31:0] bus_i [64];
  logic [31:0] bus_d [64];
  logic [31:0] mod_i [64];
  logic [31:0] mod_d [64];
  logic [31:0] mregs [32];
  logic [31:0] m_pc;
  logic [7:0]  m_gpio;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  bit chk_en = 1'b0;
  int cyc, first_req, retire_cnt;
  int rc [64];
  bit pend, prev_hold, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_imem(input logic [31:0] a);
    return a[31:8] == 24'h004000;
  endfunction

  function automatic bit in_dmem(input logic [31:0] a);
    return a[31:8] == 24'h000000;
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (in_imem(a)) return mod_i[a[7:2]];
    if (in_dmem(a)) return mod_d[a[7:2]];
    return 32'h0;
  endfunction

  function automatic bit is_illegal(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: return !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A});
      6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Architectural effect of the instruction at m_pc; called on the DUT's retire cycle.
  task automatic model_step();
    logic [31:0] ins, a, b, simm, zimm, res, ea, npc;
    logic [4:0]  dst;
    bit wr;
    ins  = mrd(m_pc);
    a    = mregs[ins[25:21]];
    b    = mregs[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    npc  = m_pc + 32'd4;
    wr   = 1'b0;
    res  = 32'h0;
    dst  = ins[20:16];
    if (!is_illegal(ins)) begin
      case (ins[31:26])
        6'h00: begin
          wr  = 1'b1;
          dst = ins[15:11];
          case (ins[5:0])
            6'h20:   res = a + b;
            6'h22:   res = a - b;
            6'h24:   res = a & b;
            6'h25:   res = a | b;
            6'h27:   res = ~(a | b);
            default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          endcase
        end
        6'h08: begin wr = 1'b1; res = a + simm; end
        6'h0C: begin wr = 1'b1; res = a & zimm; end
        6'h0D: begin wr = 1'b1; res = a | zimm; end
        6'h0F: begin wr = 1'b1; res = {ins[15:0], 16'h0}; end
        6'h23: begin wr = 1'b1; res = mrd(a + simm); end
        6'h2B: begin
          ea = a + simm;
          if (ea == GPIO_ADDR) begin
            m_gpio = b[7:0];
            chk("gpio_store_no_req", {31'b0, bus.mem_req_o}, 32'h0);
          end else begin
            chk("store_req_we", {30'b0, bus.mem_req_o, bus.mem_we_o}, 32'h3);
            chk("store_addr", bus.mem_addr_o, ea);
            chk("store_data", bus.mem_wdata_o, b);
            if (in_dmem(ea)) mod_d[ea[7:2]] = b;
          end
        end
        6'h04: if (a == b) npc = npc + {simm[29:0], 2'b00};
        6'h05: if (a != b) npc = npc + {simm[29:0], 2'b00};
        default: npc = {npc[31:28], ins[25:0], 2'b00};
      endcase
    end
    if (wr && dst != 5'd0) mregs[dst] = res;
    m_pc = npc;
  endtask

  // Compare process: once per cycle, away from both clock edges.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!chk_en) begin
        cyc = 0; first_req = -1; retire_cnt = 0; pend = 0; prev_hold = 0;
        m_pc = RESET_PC; m_gpio = 8'h00;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        for (int i = 0; i < 64; i++) begin mod_i[i] = prog[i]; mod_d[i] = dinit[i]; end
      end else begin
        cyc++;
        if (first_req < 0 && bus.mem_req_o) begin
          first_req = cyc;
          chk("first_fetch_addr", bus.mem_addr_o, RESET_PC);
          chk("first_fetch_we", {31'b0, bus.mem_we_o}, 32'h0);
        end
        if (prev_hold && bus.mem_req_o) begin
          chk("hold_addr", bus.mem_addr_o, prev_addr);
          chk("hold_we", {31'b0, bus.mem_we_o}, {31'b0, prev_we});
          chk("hold_wdata", bus.mem_wdata_o, prev_wdata);
        end
        prev_hold  = bus.mem_req_o && !bus.mem_ready_i;
        prev_addr  = bus.mem_addr_o;
        prev_we    = bus.mem_we_o;
        prev_wdata = bus.mem_wdata_o;
        if (pend) begin
          chk("model_pc", pc, m_pc);
          chk("model_gpio", {24'h0, gpio}, {24'h0, m_gpio});
          pend = 0;
        end
`ifdef MIPS_MC_TRAP_EN
        if (!is_illegal(mrd(m_pc))) chk("trap_low", {31'b0, trap}, 32'h0);
        else if (trap) begin
          chk("trap_no_req", {31'b0, bus.mem_req_o}, 32'h0);
          chk("trap_pc", pc, m_pc + 32'd4);
        end
`else
        chk("trap_low", {31'b0, trap}, 32'h0);
`endif
        if (retire) begin
          if (retire_cnt < 64) rc[retire_cnt] = cyc;
          retire_cnt++;
          model_step();
          pend = 1;
        end
      end
    end
  end

  // Memory responder: decides at each falling edge whether the coming rising edge completes.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 64; i++) begin bus_i[i] = prog[i]; bus_d[i] = dinit[i]; end
        bus.mem_ready_i = 1'b0;
        cnt = 0;
      end else if (bus.mem_req_o) begin
        if (cnt >= lat) begin
          bus.mem_ready_i = 1'b1;
          cnt = 0;
          if (in_imem(bus.mem_addr_o))      bus.mem_rdata_i = bus_i[bus.mem_addr_o[7:2]];
          else if (in_dmem(bus.mem_addr_o)) bus.mem_rdata_i = bus_d[bus.mem_addr_o[7:2]];
          else                              bus.mem_rdata_i = 32'h0;
          if (bus.mem_we_o && in_dmem(bus.mem_addr_o)) bus_d[bus.mem_addr_o[7:2]] = bus.mem_wdata_o;
        end else begin
          bus.mem_ready_i = 1'b0;
          cnt++;
        end
      end else begin
        bus.mem_ready_i = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) begin prog[i] = 32'h0; dinit[i] = 32'h0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_req", {31'b0, bus.mem_req_o}, 32'h0);
    chk("rst_retire", {31'b0, retire}, 32'h0);
    chk("rst_trap", {31'b0, trap}, 32'h0);
    chk("rst_gpio", {24'h0, gpio}, 32'h0);
    chk("rst_pc", pc, RESET_PC);
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #3;
    reset  = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic wait_retires(input int n, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #2;
      if (retire_cnt >= n) done = 1'b1;
    end
    if (!done) chk("retire_timeout", retire_cnt, n);
  endtask

  initial begin
    bit seen;
    // Arithmetic, logic, memory, branch and GPIO program with zero-wait memory.
    clear_prog();
    lat = 0;
    do_reset();
    prog[0]  = 32'h3C04_1001; prog[1]  = 32'h2001_0005; prog[2]  = 32'h2002_0007;
    prog[3]  = 32'h0022_1820; prog[4]  = 32'hAC83_0024; prog[5]  = 32'h0022_2822;
    prog[6]  = 32'h00A1_302A; prog[7]  = 32'h0022_3827; prog[8]  = 32'h0022_4024;
    prog[9]  = 32'h0022_4825; prog[10] = 32'h30AA_FFFF; prog[11] = 32'h340B_8000;
    prog[12] = 32'hAC05_0008; prog[13] = 32'h8C0C_0008; prog[14] = 32'h1400_0004;
    prog[15] = 32'h1185_0001; prog[16] = 32'h200D_0001; prog[17] = 32'hAC86_0024;
    prog[18] = 32'hAC07_000C; prog[19] = 32'hAC0A_0010; prog[20] = 32'hAC0B_0014;
    prog[21] = 32'hAC0C_0018; prog[22] = 32'hAC08_001C; prog[23] = 32'hAC09_0020;
    prog[24] = 32'h0810_0018;
    release_reset();
    wait_retires(5, 100);
    @(negedge clk); #2;
    chk("gpio_after_add", {24'h0, gpio}, 32'h0000_000C);
    chk("four_retires_cycles", rc[4] - rc[0], 16);
    wait_retires(24, 400);
    @(negedge clk); #2;
    chk("mem_sub", bus_d[2], 32'hFFFF_FFFE);
    chk("mem_nor", bus_d[3], 32'hFFFF_FFF8);
    chk("mem_andi", bus_d[4], 32'h0000_FFFE);
    chk("mem_ori", bus_d[5], 32'h0000_8000);
    chk("mem_lw", bus_d[6], 32'hFFFF_FFFE);
    chk("mem_and", bus_d[7], 32'h0000_0005);
    chk("mem_or", bus_d[8], 32'h0000_0007);
    chk("gpio_slt", {24'h0, gpio}, 32'h0000_0001);

    // Load with three wait cycles per access.
    do_reset();
    clear_prog();
    lat = 3;
    prog[0] = 32'h8C01_0000; prog[1] = 32'hAC01_0004; prog[2] = 32'h0810_0002;
    dinit[0] = 32'hCAFE_F00D;
    release_reset();
    wait_retires(1, 100);
    chk("lw_cycles", rc[0] - first_req + 1, 11);
    wait_retires(2, 100);
    @(negedge clk); #2;
    chk("lw_value_stored", bus_d[1], 32'hCAFE_F00D);

    // bne not taken, then beq back onto itself.
    do_reset();
    clear_prog();
    lat = 0;
    prog[0] = 32'h1400_0004; prog[1] = 32'h1000_FFFF;
    release_reset();
    wait_retires(1, 50);
    @(negedge clk); #2;
    chk("bne_not_taken_pc", pc, 32'h0040_0004);
    wait_retires(5, 100);
    chk("beq_cpi_a", rc[4] - rc[3], 3);
    chk("beq_cpi_b", rc[3] - rc[2], 3);
    @(negedge clk); #2;
    chk("beq_loop_pc", pc, 32'h0040_0004);

    // Illegal opcode.
    do_reset();
    clear_prog();
    prog[0] = 32'hFC00_0000; prog[1] = 32'h0810_0001;
    release_reset();
`ifdef MIPS_MC_TRAP_EN
    repeat (20) @(negedge clk);
    #2;
    chk("trap_high", {31'b0, trap}, 32'h1);
    chk("trap_req_low", {31'b0, bus.mem_req_o}, 32'h0);
    chk("trap_pc_lit", pc, 32'h0040_0004);
`else
    wait_retires(1, 50);
    @(negedge clk); #2;
    chk("nop_next_req", {31'b0, bus.mem_req_o}, 32'h1);
    chk("nop_next_addr", bus.mem_addr_o, 32'h0040_0004);
`endif

    // Reset while a load waits for ready.
    do_reset();
    clear_prog();
    lat = 20;
    prog[0] = 32'h2001_0009; prog[1] = 32'h8C01_0000; prog[2] = 32'h0810_0002;
    dinit[0] = 32'h0000_0055; dinit[1] = 32'hDEAD_BEEF;
    release_reset();
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk); #2;
      if (bus.mem_req_o && !bus.mem_we_o && bus.mem_addr_o == 32'h0) seen = 1'b1;
    end
    chk("memrd_reached", {31'b0, seen}, 32'h1);
    repeat (5) @(negedge clk);
    #3;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("abort_req", {31'b0, bus.mem_req_o}, 32'h0);
    chk("abort_pc", pc, RESET_PC);
    chk("abort_retire", {31'b0, retire}, 32'h0);
    chk("abort_gpio", {24'h0, gpio}, 32'h0);
    prog[0] = 32'hAC01_0004; prog[1] = 32'h0810_0001;
    lat = 0;
    repeat (2) @(negedge clk);
    release_reset();
    wait_retires(1, 50);
    @(negedge clk); #2;
    chk("abort_rt_unloaded", bus_d[1], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
